// File: rtl/alu_share_arb_pkg.sv
// Shared constants for the two-requester ALU arbiter: ALU_ctl codes,
// response-register states and the requester-id width.
package alu_share_arb_pkg;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  localparam int unsigned ID_W = 1;

  typedef logic [ID_W-1:0] req_id_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_share_arb_alu.sv
// Team 32-bit combinational ALU: AND/OR/ADD/SUB/SLT/NOR with zero and
// signed-overflow flags. Unknown ctl codes yield a zero result.
module alu_share_arb_alu
  import alu_share_arb_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  ctl,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (ctl)
      CTL_AND: result = a & b;
      CTL_OR:  result = a | b;
      CTL_ADD: begin
        result   = sum;
        overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      CTL_SUB: begin
        result   = diff;
        overflow = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      CTL_SLT: result = {31'b0, ($signed(a) < $signed(b))};
      CTL_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arb.sv
// Two requesters share one ALU; results land in a single response register.
// Define ALU_SHARE_ARB_FIXED_PRIO_EN for fixed priority (req0 wins) instead of round-robin.
module alu_share_arb
  import alu_share_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_ctl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_ctl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_overflow,
  output logic        rsp_err
);

  state_t      state, state_nx;
  req_id_t     grant;
  logic        issue;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctl;
  logic        alu_zero, alu_overflow, ctl_legal;

`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = req0_valid ? req_id_t'(0) : req_id_t'(1);
  end
`else
  req_id_t last_grant;

  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = req0_valid ? req_id_t'(0) : req_id_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_grant <= req_id_t'(1);
    else if (issue) last_grant <= grant;
  end
`endif

  // rst_n gate keeps ready low during reset even though state reads EMPTY
  always_comb begin
    state_nx   = state;
    issue      = rst_n && (req0_valid || req1_valid) && ((state == ST_EMPTY) || rsp_ready);
    req0_ready = issue && (grant == req_id_t'(0));
    req1_ready = issue && (grant == req_id_t'(1));
    case (state)
      ST_EMPTY: if (issue) state_nx = ST_FULL;
      ST_FULL:  if (rsp_ready && !issue) state_nx = ST_EMPTY;
      default:  state_nx = ST_EMPTY;
    endcase
  end

  assign alu_a   = (grant == req_id_t'(1)) ? req1_a   : req0_a;
  assign alu_b   = (grant == req_id_t'(1)) ? req1_b   : req0_b;
  assign alu_ctl = (grant == req_id_t'(1)) ? req1_ctl : req0_ctl;

  assign ctl_legal = (alu_ctl == CTL_AND) || (alu_ctl == CTL_OR)  ||
                     (alu_ctl == CTL_ADD) || (alu_ctl == CTL_SUB) ||
                     (alu_ctl == CTL_SLT) || (alu_ctl == CTL_NOR);

  alu_share_arb_alu u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .ctl      (alu_ctl),
    .result   (alu_result),
    .zero     (alu_zero),
    .overflow (alu_overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_EMPTY;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      state <= state_nx;
      if (issue) begin
        rsp_id       <= grant;
        rsp_result   <= alu_result;
        rsp_zero     <= alu_zero;
        rsp_overflow <= alu_overflow;
        rsp_err      <= !ctl_legal;
      end
    end
  end

  assign rsp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: ALU vector table, directed
// arbitration/backpressure/reset sequences and a randomized model comparison.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_ctl = '0, req1_ctl = '0;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_overflow, rsp_err;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;

  int tests = 0;
  int fails = 0;

  localparam longint MAX_I = 64'sd2147483647;
  localparam longint MIN_I = -64'sd2147483648;

`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  alu_share_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctl(req0_ctl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctl(req1_ctl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  ctl;
    logic [31:0] res;
    logic        z, ov, err, chk;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference ALU from the arithmetic definitions of each operation
  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl,
                                  output logic [31:0] r, output logic ov, output logic err);
    longint sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    r = '0; ov = 1'b0; err = 1'b0;
    case (ctl)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin s = sa + sb; r = s[31:0]; ov = (s > MAX_I) || (s < MIN_I); end
      4'b0110: begin s = sa - sb; r = s[31:0]; ov = (s > MAX_I) || (s < MIN_I); end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      default: err = 1'b1;
    endcase
  endfunction

  initial begin
    vecs[0]  = '{32'd5,        32'd3,        4'b0010, 32'd8,        1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{32'h7FFFFFFF, 32'd1,        4'b0010, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{32'd0,        32'd0,        4'b1100, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{32'd7,        32'd7,        4'b0110, 32'd0,        1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{32'hFFFFFFFF, 32'd2,        4'b0111, 32'd1,        1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{32'd2,        32'hFFFFFFFF, 4'b0111, 32'd0,        1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{32'hF0F0F0F0, 32'h0F0F0000, 4'b0001, 32'hFFFFF0F0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{32'h80000000, 32'd1,        4'b0110, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{32'hFFFFFFFF, 32'd1,        4'b0010, 32'd0,        1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{32'd9,        32'd4,        4'b0101, 32'd0,        1'b0, 1'b0, 1'b1, 1'b0};

    // Reset values, ready held low while in reset even with a valid request
    req0_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();
    check("rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_id", {31'b0, rsp_id}, 32'd0);
    check("rst_result", rsp_result, 32'd0);
    check("rst_flags", {29'b0, rsp_zero, rsp_overflow, rsp_err}, 32'd0);
    check("rst_ready", {30'b0, req0_ready, req1_ready}, 32'd0);

    // First issue on the first edge after release
    rst_n = 1'b1;
    req0_a = 32'd5; req0_b = 32'd3; req0_ctl = 4'b0010;
    #1 check("single_ready0", {31'b0, req0_ready}, 32'd1);
    tick();
    idle();
    check("single_valid", {31'b0, rsp_valid}, 32'd1);
    check("single_id", {31'b0, rsp_id}, 32'd0);
    check("single_result", rsp_result, 32'd8);
    check("single_flags", {30'b0, rsp_zero, rsp_overflow}, 32'd0);

    // Table of ALU vectors through requester 0, back-to-back
    for (int i = 0; i < 11; i++) begin
      req0_valid = 1'b1;
      req0_a = vecs[i].a; req0_b = vecs[i].b; req0_ctl = vecs[i].ctl;
      tick();
      idle();
      check($sformatf("vec%0d_valid", i), {31'b0, rsp_valid}, 32'd1);
      check($sformatf("vec%0d_err", i), {31'b0, rsp_err}, {31'b0, vecs[i].err});
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_result", i), rsp_result, vecs[i].res);
        check($sformatf("vec%0d_zero", i), {31'b0, rsp_zero}, {31'b0, vecs[i].z});
        check($sformatf("vec%0d_ovf", i), {31'b0, rsp_overflow}, {31'b0, vecs[i].ov});
      end
    end
    tick();
    check("drain_valid", {31'b0, rsp_valid}, 32'd0);

    // Contention after reset: req0 first, then req1
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd7; req0_ctl = 4'b0110;
    req1_valid = 1'b1; req1_a = 32'hFFFFFFFF; req1_b = 32'd2; req1_ctl = 4'b0111;
    #1 check("cont_ready", {30'b0, req0_ready, req1_ready}, 32'd2);
    tick();
    req0_valid = 1'b0;
    check("cont_id0", {31'b0, rsp_id}, 32'd0);
    check("cont_result0", rsp_result, 32'd0);
    check("cont_zero0", {31'b0, rsp_zero}, 32'd1);
    check("cont_ready1", {30'b0, req0_ready, req1_ready}, 32'd1);
    tick();
    check("cont_id1", {31'b0, rsp_id}, 32'd1);
    check("cont_result1", rsp_result, 32'd1);
    // Sustained contention: round-robin alternates, fixed priority always picks req0
    req0_valid = 1'b1;
    #1 check("cont2_ready", {30'b0, req0_ready, req1_ready}, 32'd2);
    tick();
    #1 check("cont3_ready", {30'b0, req0_ready, req1_ready}, FIXED ? 32'd2 : 32'd1);
    tick();
    check("cont3_id", {31'b0, rsp_id}, FIXED ? 32'd0 : 32'd1);
    idle();
    tick();

    // Backpressure for 3 cycles then drain-and-refill
    req0_valid = 1'b1; req0_a = 32'hF0F0; req0_b = 32'hFF00; req0_ctl = 4'b0000;
    tick();
    req0_valid = 1'b0;
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_ctl = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d_ready", i), {30'b0, req0_ready, req1_ready}, 32'd0);
      check($sformatf("bp%0d_valid", i), {31'b0, rsp_valid}, 32'd1);
      check($sformatf("bp%0d_result", i), rsp_result, 32'h0000F000);
      check($sformatf("bp%0d_id", i), {31'b0, rsp_id}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 check("bp_refill_ready", {30'b0, req0_ready, req1_ready}, 32'd1);
    tick();
    idle();
    check("bp_refill_valid", {31'b0, rsp_valid}, 32'd1);
    check("bp_refill_id", {31'b0, rsp_id}, 32'd1);
    check("bp_refill_result", rsp_result, 32'd3);
    tick();
    check("bp_drain_valid", {31'b0, rsp_valid}, 32'd0);

    // Reset while FULL: response dropped without a clock edge
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_ctl = 4'b0010;
    tick();
    idle();
    rsp_ready = 1'b0;
    check("rmid_full", {31'b0, rsp_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rmid_valid", {31'b0, rsp_valid}, 32'd0);
    check("rmid_result", rsp_result, 32'd0);
    tick();
    rst_n = 1'b1;
    #1 check("rmid_after_valid", {31'b0, rsp_valid}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 check("rmid_cont_ready", {30'b0, req0_ready, req1_ready}, 32'd2);
    tick();
    idle();
    check("rmid_cont_id", {31'b0, rsp_id}, 32'd0);

    // Randomized run against a transaction-level model
    begin
      logic        v[2];
      logic [31:0] ra[2], rb[2], rr;
      logic [3:0]  rc[2];
      logic [3:0]  ctls[8];
      logic        m_full, m_id, m_err, m_ov, m_last, g, iss, rov, rerr;
      logic [31:0] m_res;
      ctls = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1111};
      do_reset();
      m_full = 1'b0; m_last = 1'b1; m_id = 1'b0; m_res = '0; m_err = 1'b0; m_ov = 1'b0;
      v[0] = 1'b0; v[1] = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        for (int r = 0; r < 2; r++) begin
          if (!v[r]) begin
            v[r]  = ($urandom_range(0, 2) != 0);
            ra[r] = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
            rb[r] = ($urandom_range(0, 3) == 0) ? ra[r] : $urandom;
            rc[r] = ctls[$urandom_range(0, 7)];
          end
        end
        req0_valid = v[0]; req0_a = ra[0]; req0_b = rb[0]; req0_ctl = rc[0];
        req1_valid = v[1]; req1_a = ra[1]; req1_b = rb[1]; req1_ctl = rc[1];
        rsp_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (v[0] && v[1]) g = FIXED ? 1'b0 : ~m_last;
        else              g = v[1];
        iss = (v[0] || v[1]) && (!m_full || rsp_ready);
        check($sformatf("rnd%0d_ready", cyc), {30'b0, req0_ready, req1_ready},
              {30'b0, iss && !g, iss && g});
        check($sformatf("rnd%0d_valid", cyc), {31'b0, rsp_valid}, {31'b0, m_full});
        if (m_full) begin
          check($sformatf("rnd%0d_id", cyc), {31'b0, rsp_id}, {31'b0, m_id});
          check($sformatf("rnd%0d_err", cyc), {31'b0, rsp_err}, {31'b0, m_err});
          if (!m_err) begin
            check($sformatf("rnd%0d_result", cyc), rsp_result, m_res);
            check($sformatf("rnd%0d_flags", cyc), {30'b0, rsp_zero, rsp_overflow},
                  {30'b0, m_res == 32'd0, m_ov});
          end
        end
        tick();
        if (iss) begin
          ref_alu(ra[g], rb[g], rc[g], rr, rov, rerr);
          m_full = 1'b1; m_id = g; m_res = rr; m_ov = rov; m_err = rerr;
          m_last = g;
          v[g] = 1'b0;
        end else if (rsp_ready) begin
          m_full = 1'b0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 The block SHALL have these ports, in this order, one per line as name, direction, width, meaning:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  32  requester 0 source A.
- req0_b  input  32  requester 0 source B.
- req0_ctl  input  4  requester 0 ALU_ctl code.
- req1_valid, req1_ready, req1_a, req1_b, req1_ctl: same as requester 0, for requester 1.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer takes the response this cycle.
- rsp_id  output  1  requester that issued the response.
- rsp_result  output  32  ALU result.
- rsp_zero  output  1  ALU zero flag.
- rsp_overflow  output  1  ALU overflow flag.
- rsp_err  output  1  ALU_ctl code was not legal.

REQ-002 The block SHALL have no parameters; the data width is fixed at 32.

Function
REQ-003 The block SHALL share one combinational 32-bit ALU between two requesters and register its outputs into a single response register.
REQ-004 The legal ALU_ctl codes SHALL be 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT and 1100 NOR.
REQ-005 Any other ALU_ctl code SHALL be accepted, SHALL produce the ALU's raw output, and SHALL set rsp_err to 1.
REQ-006 The block SHALL have two states:
- EMPTY: the response register is free.
- FULL: the response register holds a result that has not been taken.
REQ-007 The block SHALL accept a request, called "issue", only when in EMPTY, or when in FULL with rsp_ready=1 in the same cycle (drain-and-refill, giving one operation per cycle with no bubble).
REQ-008 At most one req*_ready SHALL be high per cycle.
REQ-009 A req*_ready SHALL be high only if the matching req*_valid is high and issue is allowed; ready is combinational from valid, state and rsp_ready.
REQ-010 Arbitration SHALL be round-robin:
- If only one requester is valid, that requester is granted.
- If both are valid, the requester that was not granted last is granted.
- A last_grant register updates only on issue.
REQ-011 Latency SHALL be one cycle: an operation issued at edge N appears at edge N with rsp_valid=1 in the following cycle, with rsp_id equal to the granted requester.
REQ-012 In FULL with rsp_ready=0, all rsp_* outputs SHALL hold stable and no req*_ready SHALL be asserted.
REQ-013 State transitions SHALL be:
- EMPTY to FULL on issue.
- FULL to EMPTY on rsp_ready with no issue.
- FULL stays FULL on rsp_ready with issue (drain-and-refill).
REQ-014 rsp_result, rsp_zero and rsp_overflow SHALL follow the ALU contract:
- zero = 1 when the 32-bit result equals 0.
- overflow is the signed overflow of ADD/SUB from the MSB slice.
- SLT result is 32'h1 or 32'h0.
REQ-015 Requester inputs SHALL be sampled only in the issue cycle; requesters hold valid and operands until ready, and the block does not check this.

Reset
REQ-016 Asserting rst_n=0 SHALL asynchronously force:
- state to EMPTY and rsp_valid to 0;
- rsp_id, rsp_result, rsp_zero, rsp_overflow and rsp_err to 0;
- last_grant to 1, so requester 0 wins the first contention.
REQ-017 While rst_n=0, both req*_ready SHALL be 0.
REQ-018 Reset asserted while in FULL SHALL discard the held response without emitting it.
REQ-019 After rst_n deasserts, the first issue SHALL be possible on the first rising edge.

Configuration
REQ-020 The macro ALU_SHARE_ARB_FIXED_PRIO_EN SHALL select the arbitration policy:
- When defined, arbitration is fixed priority (requester 0 always wins contention) and the last_grant register is not built.
- When undefined, arbitration is round-robin per REQ-010.

Structure
REQ-021 A shared package SHALL hold:
- the six ALU_ctl code constants;
- the state encoding constants (EMPTY=0, FULL=1);
- the requester-id width.
REQ-022 The datapath SHALL be the existing team ALU block, instantiated once as the only sub-module, fed by a 2:1 operand/ctl mux driven by the grant.
REQ-023 The legal-code check SHALL be a local combinational compare against the package constants.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Single requester: req0 a=5, b=3, ctl=0010 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, result=8, zero=0, overflow=0.
- Contention after reset: both valid, req0 SUB 7-7, req1 SLT -1<2 -> first response id=0, result=0, zero=1; second response id=1, result=1. Once the macro is defined, req0 wins on every contention.
- Backpressure: rsp_ready=0 for 3 cycles after issue -> response held stable, both ready=0; then rsp_ready=1 with req1 valid -> drain-and-refill in the same cycle, with back-to-back rsp_valid.
- Overflow and NOR: ADD 32'h7FFFFFFF+1 -> result=32'h80000000, overflow=1; NOR 0,0 -> result=32'hFFFFFFFF, zero=0.
- Illegal code: ctl=0101 -> rsp_err=1, response still delivered.
- Reset mid-operation: rst_n low while FULL -> rsp_valid falls immediately with no clock edge; after release, contention grants req0.
